ssd_score_scanner: RTL and testbench
====================================

# ssd_score_scanner

Parametrised seven-segment score display engine that replaces the fixed four-digit, divide/modulo score path in the top level. It converts a binary score to BCD with a sequential double-dabble engine, holds the result in a display register, and time-multiplexes NUM_DIGITS active-low digits. It adds leading-zero blanking, a decimal-point mask and overflow indication. It sits between the coin/score logic and the board anode/cathode pins.

## Interface
- SCORE_WIDTH, default 10: binary score width.
- NUM_DIGITS, default 4: displayed digits, range 1–8; BCD register is 4·NUM_DIGITS bits.
- SCAN_DIV_BITS, default 18: prescaler width; the digit advances every 2^SCAN_DIV_BITS clocks.
- clk_100MHz  in  1  sole clock; all flops rise on it.
- reset_n  in  1  asynchronous, active-low reset.
- score  in  SCORE_WIDTH  binary value; sampled only when score_valid=1.
- score_valid  in  1  single-cycle load strobe.
- blank_lz  in  1  1 = blank leading zeros; digit 0 is always shown.
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of that digit.
- busy  out  1  conversion in progress.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-zero.
- seg  out  7  cathodes {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Converter FSM states:
  - IDLE: on score_valid, capture score, clear BCD, set bit counter to SCORE_WIDTH-1, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, taking the MSB of the remaining score. When counter=0, go to LOAD; otherwise decrement the counter.
  - LOAD: write BCD to the display register and the overflow flag to disp_ovf. If a load is pending, restart SHIFT with the pending value; otherwise go to IDLE.
- busy = (state ≠ IDLE).
- Overflow: at capture, ovf = (score > 10^NUM_DIGITS − 1). disp_ovf=1 makes every digit show "-" (seg=1111110). Blanking does not apply in this case.
- score_valid while busy: the value is stored in a one-deep pending register. A later strobe overwrites it (latest wins). It is consumed in LOAD.
- The display register keeps its old value until LOAD, so the display never shows a partial conversion.
- Scanner: the prescaler counts freely. On wrap, the digit index increments, wrapping from NUM_DIGITS-1 to 0.
- Leading-zero rule: digit i is blank (seg=1111111) when blank_lz=1, i>0, and digits i..NUM_DIGITS-1 are all zero.
- Hex map, active-low: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100. Any other value shows blank.
- dp = ~dp_mask[index]. It is unaffected by blanking.

## Timing
- Reset values: an all 1, seg 1111111, dp 1, busy 0, state IDLE, display register 0, disp_ovf 0, pending empty, prescaler 0, index 0.
- an, seg and dp are registered, one cycle after the index/display state.
  - First cycle after reset release: an = ~1 (digit 0 on), showing "0".
- Conversion latency: score_valid in cycle t → busy=1 from t+1. SHIFT runs for cycles t+1 … t+SCORE_WIDTH. LOAD is at t+SCORE_WIDTH+1.
  - The new digits appear on seg at t+SCORE_WIDTH+3 if that digit is selected.
  - busy falls at t+SCORE_WIDTH+2, unless a load is pending.
- score_valid in the LOAD cycle counts as pending; the restart is back-to-back with no IDLE cycle.
- Reset asserted mid-conversion: all state returns to reset values immediately and the pending value is discarded.
- blank_lz and dp_mask are sampled every cycle, with no latching.

## Structure
- Package ssd_pkg: the segment pattern constants (SEG_BLANK, SEG_DASH, digit 0–9 patterns), the FSM state enum {IDLE, SHIFT, LOAD}, and a function that computes 10^N − 1 at elaboration.
- One sub-module, bin2bcd_seq: the converter FSM plus the pending register. The top holds the display register, prescaler, index, blanking and segment decode.

## Test plan
- Reset release with SCAN_DIV_BITS=2: an cycles 1110→1101→1011→0111, 4 clocks per digit. seg=0000001 on digit 0 and blank on digits 1–3 (blank_lz=1).
- score=237, valid pulse: busy high for exactly 11 cycles. Digits read 7,3,2 then blank. With blank_lz=0 the fourth digit shows 0.
- score=999, NUM_DIGITS=2: all digits show 1111110.
- score=5 loaded, then 42 then 77 strobed during busy: the display goes 5 → 77. 42 is never displayed, and there is no IDLE gap between the conversions.
- reset_n low for one cycle mid-SHIFT: busy=0 and the display shows 0 afterward. A new strobe of 100 converts correctly.
- dp_mask=0100: dp=0 only while an=1011, including when that digit is blanked.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types, segment patterns and elaboration helpers
// for the seven-segment score display engine.
package ssd_pkg;

    // Active-low cathode patterns, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_e;

    function automatic logic [63:0] pow10_m1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep,
// latest-wins pending slot for strobes arriving while busy.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int SCORE_WIDTH = 10,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SCORE_WIDTH-1:0]  score_i,
    input  logic                    score_valid_i,
    output logic                    busy_o,
    output logic                    load_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    ovf_o
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;
    localparam logic [63:0] MAXV = pow10_m1(NUM_DIGITS);

    conv_state_e            state_q;
    logic [SCORE_WIDTH-1:0] sh_q;
    logic [BW-1:0]          bcd_q;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;
    logic                   pend_vld_q;
    logic [SCORE_WIDTH-1:0] pend_q;

    logic [BW-1:0]          adj_d;
    logic [SCORE_WIDTH-1:0] start_d;
    logic                   start_ovf_d;

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A strobe in the LOAD cycle is newer than anything pending.
    always_comb begin
        start_d = score_i;
        if (state_q == LOAD && !score_valid_i) begin
            start_d = pend_q;
        end
        start_ovf_d = (64'(start_d) > MAXV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (score_valid_i) begin
                        sh_q    <= start_d;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(SCORE_WIDTH - 1);
                        ovf_q   <= start_ovf_d;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {adj_d[BW-2:0], sh_q[SCORE_WIDTH-1]};
                    sh_q  <= sh_q << 1;
                    if (cnt_q == '0) begin
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    if (score_valid_i) begin
                        pend_vld_q <= 1'b1;
                        pend_q     <= score_i;
                    end
                end
                LOAD: begin
                    if (score_valid_i || pend_vld_q) begin
                        sh_q       <= start_d;
                        bcd_q      <= '0;
                        cnt_q      <= CW'(SCORE_WIDTH - 1);
                        ovf_q      <= start_ovf_d;
                        pend_vld_q <= 1'b0;
                        state_q    <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign load_o = (state_q == LOAD);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/ssd_score_scanner.sv
// Score display engine: BCD conversion, display register and
// multiplexed active-low digit scan with blanking and overflow.
module ssd_score_scanner
    import ssd_pkg::*;
#(
    parameter int SCORE_WIDTH   = 10,
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_BITS = 18
) (
    input  logic                   clk_100MHz,
    input  logic                   reset_n,
    input  logic [SCORE_WIDTH-1:0] score,
    input  logic                   score_valid,
    input  logic                   blank_lz,
    input  logic [NUM_DIGITS-1:0]  dp_mask,
    output logic                   busy,
    output logic [NUM_DIGITS-1:0]  an,
    output logic [6:0]             seg,
    output logic                   dp
);

    localparam int BW   = 4 * NUM_DIGITS;
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [BW-1:0]            conv_bcd;
    logic                     conv_ovf;
    logic                     conv_load;

    logic [BW-1:0]            disp_q;
    logic                     disp_ovf_q;
    logic [SCAN_DIV_BITS-1:0] presc_q;
    logic [IDXW-1:0]          idx_q;
    logic [NUM_DIGITS-1:0]    an_q;
    logic [6:0]               seg_q;
    logic                     dp_q;

    logic [IDXW-1:0]          idx_d;
    logic [NUM_DIGITS-1:0]    an_d;
    logic [6:0]               seg_d;
    logic                     dp_d;
    logic [NUM_DIGITS-1:0]    zero_above;
    logic                     run;
    logic [3:0]               digit;
    logic                     blank;

    bin2bcd_seq #(
        .SCORE_WIDTH (SCORE_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_conv (
        .clk           (clk_100MHz),
        .rst_n         (reset_n),
        .score_i       (score),
        .score_valid_i (score_valid),
        .busy_o        (busy),
        .load_o        (conv_load),
        .bcd_o         (conv_bcd),
        .ovf_o         (conv_ovf)
    );

    // zero_above[i]: digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_above = '0;
        run        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run & (disp_q[4*i +: 4] == 4'd0);
            zero_above[i] = run;
        end
    end

    always_comb begin
        digit = disp_q[4*idx_q +: 4];
        blank = blank_lz && (idx_q != '0) && zero_above[idx_q];
        if (disp_ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(digit);
        end
        an_d  = ~(ONE << idx_q);
        dp_d  = ~dp_mask[idx_q];
        idx_d = (idx_q == IDXW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                idx_q <= idx_d;
            end
            if (conv_load) begin
                disp_q     <= conv_bcd;
                disp_ovf_q <= conv_ovf;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_ssd_score_scanner.sv
// Directed self-checking bench for ssd_score_scanner: a 4-digit
// instance plus a 2-digit instance for overflow display.
module tb_ssd_score_scanner;
    import ssd_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] score;
    logic       score_valid;
    logic       blank_lz;
    logic [3:0] dp_mask;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    logic [1:0] b_dp_mask;
    logic       b_busy;
    logic [1:0] b_an;
    logic [6:0] b_seg;
    logic       b_dp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ssd_score_scanner #(
        .SCORE_WIDTH   (10),
        .NUM_DIGITS    (4),
        .SCAN_DIV_BITS (2)
    ) u_dut (
        .clk_100MHz  (clk),
        .reset_n     (reset_n),
        .score       (score),
        .score_valid (score_valid),
        .blank_lz    (blank_lz),
        .dp_mask     (dp_mask),
        .busy        (busy),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    ssd_score_scanner #(
        .SCORE_WIDTH   (10),
        .NUM_DIGITS    (2),
        .SCAN_DIV_BITS (2)
    ) u_two (
        .clk_100MHz  (clk),
        .reset_n     (reset_n),
        .score       (score),
        .score_valid (score_valid),
        .blank_lz    (blank_lz),
        .dp_mask     (b_dp_mask),
        .busy        (b_busy),
        .an          (b_an),
        .seg         (b_seg),
        .dp          (b_dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [9:0] v);
        score       = v;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int exp_n);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic wait_digit(input int i, input logic [6:0] exp,
                              input string tag);
        logic [3:0] tgt;
        int k;
        tgt = 4'b0001 << i;
        tgt = ~tgt;
        k = 0;
        tick();
        while (an !== tgt && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) chk({tag, "_timeout"}, 32'(an), 32'(tgt));
        chk(tag, 32'(seg), 32'(exp));
    endtask

    initial begin
        int n;
        int seen42;
        int busy_hi;
        int dp_blank_hits;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;

        reset_n     = 1'b0;
        score       = '0;
        score_valid = 1'b0;
        blank_lz    = 1'b1;
        dp_mask     = 4'b0000;
        b_dp_mask   = 2'b00;
        tick();
        tick();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(SEG_BLANK));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Scan order with 4 clocks per digit after release.
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_an  = 4'b0001 << ((k - 1) / 4);
            exp_an  = ~exp_an;
            exp_seg = (k <= 4) ? SEG_0 : SEG_BLANK;
            chk($sformatf("scan_an_%0d", k), 32'(an), 32'(exp_an));
            chk($sformatf("scan_seg_%0d", k), 32'(seg), 32'(exp_seg));
            if (k == 1) chk("two_seg0", 32'(b_seg), 32'(SEG_0));
        end
        tick();
        chk("scan_wrap", 32'(an), 32'hE);

        // 999: overflow on 2-digit instance, 9,9,9,blank on 4-digit.
        strobe(10'd999);
        chk("ovf_busy_rise", 32'(busy), 32'd1);
        wait_idle("ovf_busy_len", 11);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_dash_%0d", k), 32'(b_seg), 32'(SEG_DASH));
            tick();
        end
        wait_digit(0, SEG_9, "d999_0");
        wait_digit(2, SEG_9, "d999_2");
        wait_digit(3, SEG_BLANK, "d999_3");

        // 237: busy window and digit readout.
        strobe(10'd237);
        chk("b237_rise", 32'(busy), 32'd1);
        wait_idle("b237_len", 11);
        wait_digit(0, SEG_7, "d237_0");
        wait_digit(1, SEG_3, "d237_1");
        wait_digit(2, SEG_2, "d237_2");
        wait_digit(3, SEG_BLANK, "d237_3_blank");
        blank_lz = 1'b0;
        wait_digit(3, SEG_0, "d237_3_nolz");
        blank_lz = 1'b1;

        // 5, then 42 and 77 during busy: 77 wins, no idle gap.
        strobe(10'd5);
        n      = 0;
        seen42 = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            if (n == 2) begin score = 10'd42; score_valid = 1'b1; end
            if (n == 3) score_valid = 1'b0;
            if (n == 4) begin score = 10'd77; score_valid = 1'b1; end
            if (n == 5) score_valid = 1'b0;
            if (an === 4'b1110 && seg === SEG_2) seen42++;
            tick();
        end
        chk("pend_busy_len", n, 22);
        chk("pend_no42", seen42, 0);
        wait_digit(0, SEG_7, "d77_0");
        wait_digit(1, SEG_7, "d77_1");
        wait_digit(2, SEG_BLANK, "d77_2");

        // Reset mid-SHIFT with a pending value queued.
        strobe(10'd300);
        tick();
        strobe(10'd400);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_an", 32'(an), 32'hF);
        tick();
        reset_n = 1'b1;
        busy_hi = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy !== 1'b0) busy_hi++;
        end
        chk("pend_discard", busy_hi, 0);

        // Decimal point on digit 2, which is blanked here.
        dp_mask       = 4'b0100;
        dp_blank_hits = 0;
        tick();
        for (int k = 0; k < 16; k++) begin
            exp_dp = (an === 4'b1011) ? 1'b0 : 1'b1;
            chk($sformatf("dp_%0d", k), 32'(dp), 32'(exp_dp));
            if (an === 4'b1011 && seg === SEG_BLANK && dp === 1'b0)
                dp_blank_hits++;
            tick();
        end
        chk("dp_on_blank", dp_blank_hits, 4);
        dp_mask = 4'b0000;
        wait_digit(0, SEG_0, "after_rst_0");

        strobe(10'd100);
        wait_idle("b100_len", 11);
        wait_digit(0, SEG_0, "d100_0");
        wait_digit(1, SEG_0, "d100_1");
        wait_digit(2, SEG_1, "d100_2");
        wait_digit(3, SEG_BLANK, "d100_3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
